// File: rtl/video_cga_console_if.sv
// Video bus between the text-console writer (master) and the CGA CPU-side write port (slave).
interface video_cga_console_if;
  logic        busReq;
  logic        busGnt;
  logic [19:0] addr;
  logic [7:0]  wrData;
  logic        wrMem;
  logic        wrIo;

  modport master (output busReq, addr, wrData, wrMem, wrIo, input busGnt);
  modport slave  (input busReq, addr, wrData, wrMem, wrIo, output busGnt);
endinterface

// File: rtl/video_cga_console.sv
// Byte-stream text console: writes glyph/attribute pairs into CGA text VRAM and keeps the CRTC cursor in sync.
// Optional macro VIDEO_CGA_CONSOLE_TAB_EN turns 09h into a tab-stop move instead of a printable glyph.
module video_cga_console #(
  parameter int          COLS      = 80,
  parameter int          ROWS      = 25,
  parameter logic [19:0] VRAM_BASE = 20'hB8000
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic [7:0] iChar,
  input  logic       iCharValid,
  output logic       oCharReady,
  input  logic [7:0] iAttr,
  output logic       oBusy,
  video_cga_console_if.master bus
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_WR_CHR  = 4'd1;
  localparam logic [3:0] S_WR_ATR  = 4'd2;
  localparam logic [3:0] S_ADV     = 4'd3;
  localparam logic [3:0] S_CLR_CHR = 4'd4;
  localparam logic [3:0] S_CLR_ATR = 4'd5;
  localparam logic [3:0] S_CUR_IH  = 4'd6;
  localparam logic [3:0] S_CUR_VH  = 4'd7;
  localparam logic [3:0] S_CUR_IL  = 4'd8;
  localparam logic [3:0] S_CUR_VL  = 4'd9;

  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
  localparam logic [10:0] LAST_POS = 11'(COLS * ROWS - 1);

  logic [3:0]  state_q, state_d;
  logic [4:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;
  logic [7:0]  chr_q, chr_d;
  logic [7:0]  attr_q, attr_d;
  logic [10:0] clrPos_q, clrPos_d;
  logic [10:0] clrEnd_q, clrEnd_d;

  logic [10:0] pos;
  logic [4:0]  nlRow;
  logic [10:0] nlBase;
  logic [19:0] cellAddr;
  logic [19:0] clrAddr;
  logic        advance;
  logic        doNewline;
  logic        memSel;
  logic        ioSel;
  logic [19:0] addrSel;
  logic [7:0]  dataSel;

  assign pos      = 11'(row_q) * 11'(COLS) + 11'(col_q);
  assign nlRow    = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
  assign nlBase   = 11'(nlRow) * 11'(COLS);
  assign cellAddr = VRAM_BASE + {8'd0, pos, 1'b0};
  assign clrAddr  = VRAM_BASE + {8'd0, clrPos_q, 1'b0};

`ifdef VIDEO_CGA_CONSOLE_TAB_EN
  logic [6:0] tabCol;
  assign tabCol = (col_q | 7'd7) + 7'd1;
`endif

  // Column advance and newline are resolved on the exit edge of the writing state,
  // so ADV never costs a cycle in normal operation; it only recovers a stray entry.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    chr_d     = chr_q;
    attr_d    = attr_q;
    clrPos_d  = clrPos_q;
    clrEnd_d  = clrEnd_q;
    advance   = 1'b0;
    doNewline = 1'b0;
    memSel    = 1'b0;
    ioSel     = 1'b0;
    addrSel   = 20'd0;
    dataSel   = 8'd0;

    case (state_q)
      S_IDLE: begin
        if (iCharValid) begin
          chr_d   = iChar;
          attr_d  = iAttr;
          state_d = S_CUR_IH;
          case (iChar)
            8'h0D: col_d = 7'd0;
            8'h0A: doNewline = 1'b1;
            8'h08: if (col_q != 7'd0) col_d = col_q - 7'd1;
            8'h0C: begin
              row_d    = 5'd0;
              col_d    = 7'd0;
              clrPos_d = 11'd0;
              clrEnd_d = LAST_POS;
              state_d  = S_CLR_CHR;
            end
`ifdef VIDEO_CGA_CONSOLE_TAB_EN
            8'h09: begin
              if (tabCol == 7'(COLS)) begin
                col_d     = 7'd0;
                doNewline = 1'b1;
              end else begin
                col_d = tabCol;
              end
            end
`endif
            default: state_d = S_WR_CHR;
          endcase
        end
      end
      S_WR_CHR: begin
        memSel  = 1'b1;
        addrSel = cellAddr;
        dataSel = chr_q;
        if (bus.busGnt) state_d = S_WR_ATR;
      end
      S_WR_ATR: begin
        memSel  = 1'b1;
        addrSel = cellAddr + 20'd1;
        dataSel = attr_q;
        if (bus.busGnt) advance = 1'b1;
      end
      S_ADV: advance = 1'b1;
      S_CLR_CHR: begin
        memSel  = 1'b1;
        addrSel = clrAddr;
        dataSel = 8'h20;
        if (bus.busGnt) state_d = S_CLR_ATR;
      end
      S_CLR_ATR: begin
        memSel  = 1'b1;
        addrSel = clrAddr + 20'd1;
        dataSel = attr_q;
        if (bus.busGnt) begin
          if (clrPos_q == clrEnd_q) begin
            state_d = S_CUR_IH;
          end else begin
            clrPos_d = clrPos_q + 11'd1;
            state_d  = S_CLR_CHR;
          end
        end
      end
      S_CUR_IH: begin
        ioSel   = 1'b1;
        addrSel = 20'h003D4;
        dataSel = 8'h0E;
        if (bus.busGnt) state_d = S_CUR_VH;
      end
      S_CUR_VH: begin
        ioSel   = 1'b1;
        addrSel = 20'h003D5;
        dataSel = {5'd0, pos[10:8]};
        if (bus.busGnt) state_d = S_CUR_IL;
      end
      S_CUR_IL: begin
        ioSel   = 1'b1;
        addrSel = 20'h003D4;
        dataSel = 8'h0F;
        if (bus.busGnt) state_d = S_CUR_VL;
      end
      S_CUR_VL: begin
        ioSel   = 1'b1;
        addrSel = 20'h003D5;
        dataSel = pos[7:0];
        if (bus.busGnt) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      state_d = S_CUR_IH;
      if (col_q == LAST_COL) begin
        col_d     = 7'd0;
        doNewline = 1'b1;
      end else begin
        col_d = col_q + 7'd1;
      end
    end

    // Newline wraps the row without scrolling and then blanks the row it lands on.
    if (doNewline) begin
      row_d    = nlRow;
      clrPos_d = nlBase;
      clrEnd_d = nlBase + 11'(COLS - 1);
      state_d  = S_CLR_CHR;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q  <= S_IDLE;
      row_q    <= 5'd0;
      col_q    <= 7'd0;
      chr_q    <= 8'd0;
      attr_q   <= 8'd0;
      clrPos_q <= 11'd0;
      clrEnd_q <= 11'd0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      chr_q    <= chr_d;
      attr_q   <= attr_d;
      clrPos_q <= clrPos_d;
      clrEnd_q <= clrEnd_d;
    end
  end

  assign oBusy       = (state_q != S_IDLE);
  assign oCharReady  = (state_q == S_IDLE) & ~iRst;
  assign bus.busReq  = oBusy;
  assign bus.addr    = addrSel;
  assign bus.wrData  = dataSel;
  assign bus.wrMem   = memSel & bus.busGnt & ~iRst;
  assign bus.wrIo    = ioSel & bus.busGnt & ~iRst;

endmodule

// File: tb/tb_video_cga_console.sv
// Self-checking bench for video_cga_console: a text-console model predicts every bus write in order.
// Build with VIDEO_CGA_CONSOLE_TAB_EN defined to exercise the tab variant.
module tb_video_cga_console;

  logic       iClk = 1'b0;
  logic       iRst = 1'b1;
  logic [7:0] iChar = 8'd0;
  logic       iCharValid = 1'b0;
  logic [7:0] iAttr = 8'd0;
  logic       oCharReady;
  logic       oBusy;

  int testCount = 0;
  int failCount = 0;
  int memCount  = 0;
  int mRow = 0;
  int mCol = 0;
  int gntMode = 1;
  logic gntRand = 1'b1;
  logic [29:0] expQ[$];

  video_cga_console_if bus();

  video_cga_console dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iChar      (iChar),
    .iCharValid (iCharValid),
    .oCharReady (oCharReady),
    .iAttr      (iAttr),
    .oBusy      (oBusy),
    .bus        (bus)
  );

  always #5 iClk = ~iClk;

  assign bus.busGnt = (gntMode == 2) ? gntRand : (gntMode == 1);

  initial begin
    forever begin
      @(posedge iClk);
      #1 gntRand = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Reference model: screen cursor plus the ordered list of bus writes the console must issue.
  task automatic pushWr(input bit isIo, input int addr, input int data);
    expQ.push_back({~isIo, isIo, 20'(addr), 8'(data)});
  endtask

  task automatic modelClear(input int first, input int count, input int attr);
    for (int i = 0; i < count; i++) begin
      pushWr(1'b0, 'hB8000 + 2 * (first + i), 'h20);
      pushWr(1'b0, 'hB8000 + 2 * (first + i) + 1, attr);
    end
  endtask

  task automatic modelNewline(input int attr);
    mRow = (mRow + 1) % 25;
    modelClear(mRow * 80, 80, attr);
  endtask

  task automatic modelChar(input int c, input int a);
    int p;
    if (c == 'h0D) mCol = 0;
    else if (c == 'h0A) modelNewline(a);
    else if (c == 'h08) begin
      if (mCol > 0) mCol--;
    end
    else if (c == 'h0C) begin
      modelClear(0, 2000, a);
      mRow = 0;
      mCol = 0;
    end
`ifdef VIDEO_CGA_CONSOLE_TAB_EN
    else if (c == 'h09) begin
      mCol = (mCol | 7) + 1;
      if (mCol == 80) begin
        mCol = 0;
        modelNewline(a);
      end
    end
`endif
    else begin
      p = mRow * 80 + mCol;
      pushWr(1'b0, 'hB8000 + 2 * p, c);
      pushWr(1'b0, 'hB8000 + 2 * p + 1, a);
      mCol++;
      if (mCol == 80) begin
        mCol = 0;
        modelNewline(a);
      end
    end
    p = mRow * 80 + mCol;
    pushWr(1'b1, 'h3D4, 'h0E);
    pushWr(1'b1, 'h3D5, p / 256);
    pushWr(1'b1, 'h3D4, 'h0F);
    pushWr(1'b1, 'h3D5, p % 256);
  endtask

  always @(negedge iClk) begin
    if (!iRst && (bus.wrMem || bus.wrIo)) begin
      logic [29:0] e;
      checkOutput("strobeGnt", 32'(bus.busGnt), 32'd1);
      if (bus.wrMem) memCount++;
      if (expQ.size() == 0) begin
        checkOutput("strobeExpected", 32'(expQ.size()), 32'd1);
      end else begin
        e = expQ.pop_front();
        checkOutput("busWrite", {2'b0, bus.wrMem, bus.wrIo, bus.addr, bus.wrData}, {2'b0, e});
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] c, input logic [7:0] a);
    int n = 0;
    while (!oCharReady && n < 20000) begin
      @(negedge iClk);
      n++;
    end
    if (!oCharReady) begin
      checkOutput("readyTimeout", 32'(oCharReady), 32'd1);
      return;
    end
    iChar = c;
    iAttr = a;
    iCharValid = 1'b1;
    modelChar(int'(c), int'(a));
    @(posedge iClk);
    #1 iCharValid = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while (oBusy && n < budget) begin
      @(negedge iClk);
      n++;
    end
    checkOutput("idleTimeout", 32'(oBusy), 32'd0);
  endtask

  task automatic resetDut();
    iRst = 1'b1;
    iCharValid = 1'b0;
    expQ.delete();
    mRow = 0;
    mCol = 0;
    @(posedge iClk);
    #1 iRst = 1'b0;
    @(negedge iClk);
    checkOutput("rstReady", 32'(oCharReady), 32'd1);
    checkOutput("rstBusReq", 32'(bus.busReq), 32'd0);
    checkOutput("rstBusy", 32'(oBusy), 32'd0);
    checkOutput("rstAddr", 32'(bus.addr), 32'd0);
    checkOutput("rstData", 32'(bus.wrData), 32'd0);
    checkOutput("rstStrobes", {30'd0, bus.wrMem, bus.wrIo}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d failed so far", failCount);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int memBefore;
    int ffCount;
    int r;
    logic [7:0] c;

    // Single printable char with continuous grant: cycle-exact strobe placement.
    gntMode = 1;
    resetDut();
    applyStimulus(8'h41, 8'h1F);
    for (int k = 1; k <= 7; k++) begin
      @(negedge iClk);
      checkOutput($sformatf("latKind%0d", k), {30'd0, bus.wrMem, bus.wrIo},
                  (k <= 2) ? 32'd2 : ((k <= 6) ? 32'd1 : 32'd0));
    end
    checkOutput("latReady", 32'(oCharReady), 32'd1);
    checkOutput("t1Queue", 32'(expQ.size()), 32'd0);

    // A full line forces a wrap and a row-1 clear.
    resetDut();
    for (int i = 0; i < 80; i++) applyStimulus(8'h41, 8'h07);
    waitIdle(2000);
    checkOutput("t2Queue", 32'(expQ.size()), 32'd0);

    // Newline from the last row wraps to row 0 and keeps the column.
    resetDut();
    for (int i = 0; i < 24; i++) applyStimulus(8'h0A, 8'h07);
    for (int i = 0; i < 5; i++) applyStimulus(8'h78, 8'h07);
    applyStimulus(8'h0A, 8'h07);
    waitIdle(2000);
    checkOutput("t3Queue", 32'(expQ.size()), 32'd0);

    // Grant withdrawn while the attribute write is pending.
    resetDut();
    applyStimulus(8'h41, 8'h1F);
    @(posedge iClk);
    #1 gntMode = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge iClk);
      checkOutput("holdStrobe", {30'd0, bus.wrMem, bus.wrIo}, 32'd0);
      checkOutput("holdAddr", 32'(bus.addr), 32'hB8001);
      checkOutput("holdBusReq", 32'(bus.busReq), 32'd1);
    end
    @(posedge iClk);
    #1 gntMode = 1;
    waitIdle(200);
    checkOutput("t4Queue", 32'(expQ.size()), 32'd0);

    // Reset in the middle of a row clear aborts it; the next char lands at the origin.
    resetDut();
    applyStimulus(8'h0A, 8'h07);
    repeat (20) @(posedge iClk);
    #1;
    resetDut();
    applyStimulus(8'h5A, 8'h4E);
    waitIdle(200);
    checkOutput("t5Queue", 32'(expQ.size()), 32'd0);

    // Tab from column 3.
    resetDut();
    for (int i = 0; i < 3; i++) applyStimulus(8'h62, 8'h02);
    waitIdle(200);
    memBefore = memCount;
    applyStimulus(8'h09, 8'h02);
    waitIdle(200);
`ifdef VIDEO_CGA_CONSOLE_TAB_EN
    checkOutput("tabMemWr", 32'(memCount - memBefore), 32'd0);
`else
    checkOutput("tabMemWr", 32'(memCount - memBefore), 32'd2);
`endif
    checkOutput("t6Queue", 32'(expQ.size()), 32'd0);

    // Random stream with random grant.
    resetDut();
    gntMode = 2;
    ffCount = 0;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8) c = 8'h0A;
      else if (r < 13) c = 8'h0D;
      else if (r < 18) c = 8'h08;
      else if (r < 22) c = 8'h09;
      else if (r == 22 && ffCount < 2) begin
        c = 8'h0C;
        ffCount++;
      end else begin
        c = 8'($urandom_range(0, 255));
        if (c == 8'h0C) c = 8'h41;
      end
      applyStimulus(c, 8'($urandom_range(0, 255)));
    end
    waitIdle(20000);
    checkOutput("t7Queue", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
